// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader; optional checksum word under LOADER_CHECKSUM_EN
module imem_loader #(
  parameter int N      = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [N-1:0]      wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic              err
);

  localparam int BPW  = N / 8;
  localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BPW - 1);
  localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state, state_n;
  logic              ready_r, ready_n;
  logic              we_r, we_n;
  logic [ADDR_W-1:0] waddr_r, waddr_n;
  logic [N-1:0]      wdata_r, wdata_n;
  logic [ADDR_W:0]   total, total_n;
  logic [ADDR_W:0]   wcnt, wcnt_n, wcnt_inc;
  logic [BC_W-1:0]   bcnt, bcnt_n;
  logic [N-1:0]      asm_r, asm_n, word_n;
`ifdef LOADER_CHECKSUM_EN
  logic [N-1:0]      chk, chk_n;
  logic              err_r, err_n;
`endif

  // State, handshake and write-port registers; memory itself is never touched by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ready_r <= 1'b0;
      we_r    <= 1'b0;
      waddr_r <= '0;
      wdata_r <= '0;
      total   <= '0;
      wcnt    <= '0;
      bcnt    <= '0;
      asm_r   <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk     <= '0;
      err_r   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      ready_r <= ready_n;
      we_r    <= we_n;
      waddr_r <= waddr_n;
      wdata_r <= wdata_n;
      total   <= total_n;
      wcnt    <= wcnt_n;
      bcnt    <= bcnt_n;
      asm_r   <= asm_n;
`ifdef LOADER_CHECKSUM_EN
      chk     <= chk_n;
      err_r   <= err_n;
`endif
    end
  end

  // Next-state logic: byte packing, word writes and load termination
  always_comb begin
    state_n  = state;
    ready_n  = ready_r;
    we_n     = 1'b0;
    waddr_n  = waddr_r;
    wdata_n  = wdata_r;
    total_n  = total;
    wcnt_n   = wcnt;
    bcnt_n   = bcnt;
    asm_n    = asm_r;
    wcnt_inc = wcnt + 1'b1;
    word_n   = asm_r;
    for (int k = 0; k < BPW; k++) begin
      if (bcnt == BC_W'(k)) word_n[8*k +: 8] = byte_data;
    end
`ifdef LOADER_CHECKSUM_EN
    chk_n = chk;
    err_n = err_r;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          wcnt_n  = '0;
          bcnt_n  = '0;
          asm_n   = '0;
          total_n = (num_words > DEPTH) ? DEPTH : num_words;
`ifdef LOADER_CHECKSUM_EN
          chk_n   = '0;
          err_n   = 1'b0;
`endif
          if (num_words == '0) begin
            state_n = DONE;
            ready_n = 1'b0;
          end else begin
            state_n = LOAD;
            ready_n = 1'b1;
          end
        end
      end
      LOAD: begin
        // ready low inside LOAD only marks the final write cycle
        if (!ready_r) begin
          state_n = DONE;
        end else if (byte_valid) begin
          if (bcnt != LAST_BYTE) begin
            bcnt_n = bcnt + 1'b1;
            asm_n  = word_n;
          end else begin
            bcnt_n = '0;
            asm_n  = '0;
`ifdef LOADER_CHECKSUM_EN
            if (wcnt == total) begin
              // trailing checksum word: compared, never written
              state_n = DONE;
              ready_n = 1'b0;
              err_n   = (word_n != chk);
            end else begin
              we_n    = 1'b1;
              waddr_n = wcnt[ADDR_W-1:0];
              wdata_n = word_n;
              wcnt_n  = wcnt_inc;
              chk_n   = chk ^ word_n;
            end
`else
            we_n    = 1'b1;
            waddr_n = wcnt[ADDR_W-1:0];
            wdata_n = word_n;
            wcnt_n  = wcnt_inc;
            if (wcnt_inc == total) ready_n = 1'b0;
`endif
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign byte_ready = ready_r;
  assign we         = we_r;
  assign waddr      = waddr_r;
  assign wdata      = wdata_r;
  assign busy       = (state == LOAD);
  assign done       = (state == DONE);
`ifdef LOADER_CHECKSUM_EN
  assign err        = err_r;
  assign cpu_hold   = (state != DONE) | err_r;
`else
  assign err        = 1'b0;
  assign cpu_hold   = (state != DONE);
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  localparam int N      = 32;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [N-1:0]      wdata;
  logic              busy;
  logic              done;
  logic              cpu_hold;
  logic              err;

  int tests_run = 0;
  int failed    = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [N-1:0]      wr_data[$];
  logic [N-1:0]      exp_q[$];

  imem_loader #(.N(N), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_words(num_words),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done),
    .cpu_hold(cpu_hold), .err(err)
  );

  always #5 clk = ~clk;

  // log every write pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (we) begin
      wr_addr.push_back(waddr);
      wr_data.push_back(wdata);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    num_words = 7'(n);
    step(1);
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) begin
      byte_valid = 1'b0;
      step(1);
    end
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 100) begin
      step(1);
      n++;
    end
    if (!byte_ready) begin
      tests_run++;
      failed++;
      $display("FAIL handshake_timeout byte=%h byte_ready never rose within 100 cycles", b);
    end
    step(1);
  endtask

  task automatic send_words(input bit gap, input logic [N-1:0] chk_flip);
    logic [N-1:0] w;
    logic [N-1:0] chk;
    chk = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      w   = exp_q[i];
      chk = chk ^ w;
      for (int k = 0; k < N/8; k++) send_byte(w[8*k +: 8], gap);
    end
`ifdef LOADER_CHECKSUM_EN
    chk = chk ^ chk_flip;
    for (int k = 0; k < N/8; k++) send_byte(chk[8*k +: 8], gap);
`else
    chk = chk_flip;
`endif
    byte_valid = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; num_words = '0; byte_data = '0; byte_valid = 1'b0;
    step(3);
    tests_run++;
    if ({byte_ready, we, waddr, wdata, busy, done, cpu_hold, err} !==
        {1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      failed++;
      $display("FAIL por_outputs got rdy=%b we=%b wa=%h wd=%h busy=%b done=%b hold=%b err=%b want 0 0 00 00000000 0 0 1 0",
               byte_ready, we, waddr, wdata, busy, done, cpu_hold, err);
    end
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_basic();
    clear_log();
    exp_q = '{32'hf8000000, 32'hf8008001, 32'hf8010002};
    do_start(3);
    tests_run++;
    if ({busy, byte_ready, done, cpu_hold} !== 4'b1101) begin
      failed++;
      $display("FAIL basic_enter_load got busy/rdy/done/hold=%b want 1101", {busy, byte_ready, done, cpu_hold});
    end
    send_words(1'b0, '0);
`ifndef LOADER_CHECKSUM_EN
    tests_run++;
    if ({we, byte_ready, done} !== 3'b100) begin
      failed++;
      $display("FAIL basic_last_write_cycle got we/rdy/done=%b want 100", {we, byte_ready, done});
    end
    step(1);
`endif
    tests_run++;
    if ({done, cpu_hold, busy, err} !== 4'b1000) begin
      failed++;
      $display("FAIL basic_done got done/hold/busy/err=%b want 1000", {done, cpu_hold, busy, err});
    end
    step(3);
    tests_run++;
    if (wr_addr.size() !== 3) begin
      failed++;
      $display("FAIL basic_write_count got %0d want 3", wr_addr.size());
    end
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      tests_run++;
      if (wr_addr[i] !== 6'(i) || wr_data[i] !== exp_q[i]) begin
        failed++;
        $display("FAIL basic_write%0d got %h@%0d want %h@%0d", i, wr_data[i], wr_addr[i], exp_q[i], i);
      end
    end
  endtask

  task automatic test_reset_midload();
    clear_log();
    do_start(3);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    reset_n = 1'b0;
    #2;
    tests_run++;
    if ({byte_ready, we, waddr, wdata, busy, done, cpu_hold, err} !==
        {1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      failed++;
      $display("FAIL midload_reset got rdy=%b we=%b wa=%h wd=%h busy=%b done=%b hold=%b err=%b want 0 0 00 00000000 0 0 1 0",
               byte_ready, we, waddr, wdata, busy, done, cpu_hold, err);
    end
    byte_valid = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(2);
    tests_run++;
    if (wr_addr.size() !== 0 || byte_ready !== 1'b0) begin
      failed++;
      $display("FAIL midload_no_write got writes=%0d rdy=%b want 0 0", wr_addr.size(), byte_ready);
    end
  endtask

  task automatic test_stall();
    clear_log();
    exp_q = '{32'hf8000000, 32'hf8008001, 32'hf8010002};
    do_start(3);
    send_words(1'b1, '0);
`ifndef LOADER_CHECKSUM_EN
    tests_run++;
    if ({we, byte_ready, done} !== 3'b100) begin
      failed++;
      $display("FAIL stall_last_write_cycle got we/rdy/done=%b want 100", {we, byte_ready, done});
    end
    step(1);
`endif
    tests_run++;
    if ({done, cpu_hold, busy} !== 3'b100) begin
      failed++;
      $display("FAIL stall_done got done/hold/busy=%b want 100", {done, cpu_hold, busy});
    end
    step(3);
    tests_run++;
    if (wr_addr.size() !== 3) begin
      failed++;
      $display("FAIL stall_write_count got %0d want 3", wr_addr.size());
    end
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      tests_run++;
      if (wr_addr[i] !== 6'(i) || wr_data[i] !== exp_q[i]) begin
        failed++;
        $display("FAIL stall_write%0d got %h@%0d want %h@%0d", i, wr_data[i], wr_addr[i], exp_q[i], i);
      end
    end
  endtask

  task automatic test_boundary();
    int bad;
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(1);
    clear_log();
    do_start(0);
    tests_run++;
    if ({done, cpu_hold, busy, byte_ready} !== 4'b1000) begin
      failed++;
      $display("FAIL zero_words_done got done/hold/busy/rdy=%b want 1000", {done, cpu_hold, busy, byte_ready});
    end
    step(3);
    tests_run++;
    if (wr_addr.size() !== 0) begin
      failed++;
      $display("FAIL zero_words_writes got %0d want 0", wr_addr.size());
    end
    exp_q.delete();
    for (int w = 0; w < 64; w++) exp_q.push_back({8'ha5, 8'(w), ~8'(w), 8'(w * 3)});
    do_start(100);
    send_words(1'b0, '0);
`ifndef LOADER_CHECKSUM_EN
    step(1);
`endif
    tests_run++;
    if ({done, cpu_hold, busy} !== 3'b100) begin
      failed++;
      $display("FAIL clamp_done got done/hold/busy=%b want 100", {done, cpu_hold, busy});
    end
    byte_data  = 8'h5a;
    byte_valid = 1'b1;
    step(4);
    byte_valid = 1'b0;
    tests_run++;
    if (wr_addr.size() !== 64) begin
      failed++;
      $display("FAIL clamp_write_count got %0d want 64", wr_addr.size());
    end
    bad = 0;
    for (int i = 0; i < 64 && i < wr_addr.size(); i++) begin
      if (wr_addr[i] !== 6'(i) || wr_data[i] !== exp_q[i]) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      failed++;
      $display("FAIL clamp_write_contents got %0d bad entries want 0", bad);
    end
  endtask

  task automatic test_reload();
    clear_log();
    exp_q = '{32'hcb0e01ce};
    do_start(1);
    tests_run++;
    if ({done, busy, cpu_hold} !== 3'b011) begin
      failed++;
      $display("FAIL reload_enter got done/busy/hold=%b want 011", {done, busy, cpu_hold});
    end
    send_words(1'b0, '0);
`ifndef LOADER_CHECKSUM_EN
    step(1);
`endif
    tests_run++;
    if ({done, cpu_hold} !== 2'b10) begin
      failed++;
      $display("FAIL reload_done got done/hold=%b want 10", {done, cpu_hold});
    end
    step(2);
    tests_run++;
    if (wr_addr.size() !== 1 || (wr_addr.size() > 0 && (wr_data[0] !== 32'hcb0e01ce || wr_addr[0] !== 6'd0))) begin
      failed++;
      $display("FAIL reload_write got count=%0d first=%h want 1 cb0e01ce@0", wr_addr.size(),
               (wr_data.size() > 0) ? wr_data[0] : 32'hx);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_log();
    exp_q = '{32'hf8000000, 32'hf8008001};
    do_start(2);
    send_words(1'b0, 32'h0);
    tests_run++;
    if ({done, err, cpu_hold, we} !== 4'b1000) begin
      failed++;
      $display("FAIL chk_good got done/err/hold/we=%b want 1000", {done, err, cpu_hold, we});
    end
    do_start(2);
    send_words(1'b0, 32'h00008001);
    tests_run++;
    if ({done, err, cpu_hold} !== 3'b111) begin
      failed++;
      $display("FAIL chk_bad got done/err/hold=%b want 111", {done, err, cpu_hold});
    end
    step(2);
    tests_run++;
    if (wr_addr.size() !== 4) begin
      failed++;
      $display("FAIL chk_write_count got %0d want 4", wr_addr.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_reset_midload();
    test_stall();
    test_boundary();
    test_reload();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
